// File: rtl/sap2_io_pkg.sv
// Shared types and defaults for the serial input port.
package sap2_io_pkg;
  typedef enum logic {RX_DATA = 1'b0, RX_PARITY = 1'b1} rx_state_e;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/serial_input_port_if.sv
// Control/status handshake between the serial input port and its controller.
// parity_err exists only when SIPORT_PARITY_EN is defined.
interface serial_input_port_if;
  logic serial_in;
  logic bit_valid;
  logic rd_en;
  logic ready;
  logic overrun;
`ifdef SIPORT_PARITY_EN
  logic parity_err;
  modport master (output serial_in, bit_valid, rd_en, input ready, overrun, parity_err);
  modport slave  (input serial_in, bit_valid, rd_en, output ready, overrun, parity_err);
`else
  modport master (output serial_in, bit_valid, rd_en, input ready, overrun);
  modport slave  (input serial_in, bit_valid, rd_en, output ready, overrun);
`endif
endinterface

// File: rtl/serial_shift_reg.sv
// Shift register with selectable entry end plus a data-bit counter.
// word_next is the value the register takes on the coming edge.
module serial_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] word_next,
  output logic              at_last
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     cnt;

  // LSB-first enters at the top and walks down, so bit 0 ends up holding the first bit
  always_comb begin
    word_next = sr;
    if (shift_en)
      word_next = MSB_FIRST ? {sr[DATA_W-2:0], serial_in} : {serial_in, sr[DATA_W-1:1]};
  end

  assign at_last = (cnt == LAST_IDX);

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word_next;
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/serial_input_port.sv
// Serial-to-parallel input port with hold register and tri-state W bus output.
// Optional even-parity bit per word when SIPORT_PARITY_EN is defined.
module serial_input_port
  import sap2_io_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               CLK,
  input  logic               nCLR,
  serial_input_port_if.slave bus,
  output tri [DATA_W-1:0]    WBUS
);
  logic [DATA_W-1:0] word_next, hold;
  logic              at_last, shift_en, complete;
  logic              ready_q, overrun_q, rd_hit, load, drop;

  serial_shift_reg #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_sr (
    .CLK      (CLK),
    .nCLR     (nCLR),
    .shift_en (shift_en),
    .serial_in(bus.serial_in),
    .word_next(word_next),
    .at_last  (at_last)
  );

`ifdef SIPORT_PARITY_EN
  rx_state_e state, state_nxt;
  logic      perr_q, perr_nxt;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) state <= RX_DATA;
    else       state <= state_nxt;
  end

  // Data bits shift in RX_DATA; the parity bit never enters the shift register
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    complete  = 1'b0;
    case (state)
      RX_DATA: begin
        shift_en = bus.bit_valid;
        if (bus.bit_valid && at_last) state_nxt = RX_PARITY;
      end
      RX_PARITY: begin
        complete = bus.bit_valid;
        if (bus.bit_valid) state_nxt = RX_DATA;
      end
      default: state_nxt = RX_DATA;
    endcase
  end

  assign perr_nxt       = ^{word_next, bus.serial_in};
  assign bus.parity_err = perr_q;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR)     perr_q <= 1'b0;
    else if (load) perr_q <= perr_nxt;
  end
`else
  assign shift_en = bus.bit_valid;
  assign complete = bus.bit_valid && at_last;
`endif

  assign rd_hit = ready_q && bus.rd_en;
  assign load   = complete && (!ready_q || bus.rd_en);
  assign drop   = complete && ready_q && !bus.rd_en;

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      hold      <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        hold    <= word_next;
        ready_q <= 1'b1;
      end else if (rd_hit) begin
        ready_q <= 1'b0;
      end
      if (drop)        overrun_q <= 1'b1;
      else if (rd_hit) overrun_q <= 1'b0;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.overrun = overrun_q;
  assign WBUS        = rd_hit ? hold : {DATA_W{1'bz}};
endmodule

// File: tb/tb_serial_input_port.sv
// Randomized bench for serial_input_port: LSB-first and MSB-first instances share
// stimulus and are checked against a word-level model built from a bit queue.
module tb_serial_input_port;
  import sap2_io_pkg::*;
  localparam int DW = 8;
`ifdef SIPORT_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = DW + (PAR ? 1 : 0);

  logic CLK, nCLR;
  wire [DW-1:0] wbus0, wbus1;
  serial_input_port_if bus0 ();
  serial_input_port_if bus1 ();

  serial_input_port #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut0 (.CLK(CLK), .nCLR(nCLR), .bus(bus0), .WBUS(wbus0));
  serial_input_port #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut1 (.CLK(CLK), .nCLR(nCLR), .bus(bus1), .WBUS(wbus1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk = 0, n_err = 0;
  bit bits[$];
  logic [DW-1:0] m_hold0 = '0, m_hold1 = '0, rd_w0 = '0, rd_w1 = '0;
  bit m_ready = 0, m_ovr = 0, m_pe = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A 2-state simulator resolves an undriven bus to 0, a 4-state one to Z
  function automatic bit idle(input logic [DW-1:0] v);
    return (v === {DW{1'bz}}) || (v === '0);
  endfunction

  task automatic drive(input bit sin, input bit bv, input bit rd);
    bus0.serial_in = sin; bus0.bit_valid = bv; bus0.rd_en = rd;
    bus1.serial_in = sin; bus1.bit_valid = bv; bus1.rd_en = rd;
  endtask

  task automatic model_reset();
    bits.delete();
    m_ready = 0; m_ovr = 0; m_pe = 0; m_hold0 = '0; m_hold1 = '0;
  endtask

  // Word-level rules: collect bits until a frame is full, then decide load/drop
  task automatic model_edge(input bit sin, input bit bv, input bit rd);
    bit done = 0;
    bit rd_hit = rd && m_ready;
    int w0 = 0, w1 = 0, ones = 0;
    if (bv) begin
      bits.push_back(sin);
      if (bits.size() == NB) begin
        done = 1;
        for (int i = 0; i < DW; i++) begin
          w0 += int'(bits[i]) * (1 << i);
          w1 += int'(bits[i]) * (1 << (DW - 1 - i));
        end
        foreach (bits[i]) ones += int'(bits[i]);
        bits.delete();
      end
    end
    if (done && (!m_ready || rd)) begin
      m_hold0 = DW'(w0); m_hold1 = DW'(w1); m_pe = (ones % 2) == 1; m_ready = 1;
    end else if (done) begin
      m_ovr = 1;
    end else if (rd_hit) begin
      m_ready = 0;
    end
    if (rd_hit) m_ovr = 0;
  endtask

  task automatic check_status(input string pfx);
    chk({pfx, "_ready0"}, 32'(bus0.ready), 32'(m_ready));
    chk({pfx, "_ready1"}, 32'(bus1.ready), 32'(m_ready));
    chk({pfx, "_ovr0"}, 32'(bus0.overrun), 32'(m_ovr));
    chk({pfx, "_ovr1"}, 32'(bus1.overrun), 32'(m_ovr));
`ifdef SIPORT_PARITY_EN
    chk({pfx, "_perr0"}, 32'(bus0.parity_err), 32'(m_pe));
    chk({pfx, "_perr1"}, 32'(bus1.parity_err), 32'(m_pe));
`endif
  endtask

  task automatic step(input bit sin, input bit bv, input bit rd);
    @(negedge CLK);
    drive(sin, bv, rd);
    #1;
    if (rd && m_ready) begin
      rd_w0 = wbus0; rd_w1 = wbus1;
      chk("wbus_lsb", 32'(wbus0), 32'(m_hold0));
      chk("wbus_msb", 32'(wbus1), 32'(m_hold1));
    end else begin
      chk("wbus0_idle", 32'(idle(wbus0)), 32'd1);
      chk("wbus1_idle", 32'(idle(wbus1)), 32'd1);
    end
    @(posedge CLK);
    model_edge(sin, bv, rd);
    #1;
    check_status("edge");
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b1);
    nCLR = 1'b0;
    #1;
    model_reset();
    check_status("rst");
    chk("rst_wbus0", 32'(idle(wbus0)), 32'd1);
    chk("rst_wbus1", 32'(idle(wbus1)), 32'd1);
    @(negedge CLK);
    nCLR = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Data bits go out w[0] first; with parity the frame ends on pbit
  task automatic send_word(input logic [DW-1:0] w, input bit rd_last, input bit pbit, input bit gappy);
    for (int i = 0; i < DW; i++) begin
      if (gappy) step(1'($urandom), 1'b0, 1'b0);
      step(w[i], 1'b1, (!PAR && i == DW - 1) ? rd_last : 1'b0);
    end
    if (PAR) step(pbit, 1'b1, rd_last);
  endtask

  task automatic read_word();
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    nCLR = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    pulse_reset();

    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    chk("basic_ready", 32'(bus0.ready), 32'd1);
    read_word();
    chk("basic_lsb", 32'(rd_w0), 32'h4D);
    chk("basic_msb", 32'(rd_w1), 32'hB2);

    send_word(8'h4D, 1'b0, 1'b0, 1'b1);
    read_word();
    chk("gappy_lsb", 32'(rd_w0), 32'h4D);

    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 32'(bus0.overrun), 32'd1);
    read_word();
    chk("ovr_keep_old", 32'(rd_w0), 32'h4D);
    chk("ovr_clear", 32'(bus0.overrun), 32'd0);

    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'h12, 1'b1, 1'b0, 1'b0);
    chk("same_edge_rdval", 32'(rd_w0), 32'h4D);
    chk("same_edge_ready", 32'(bus0.ready), 32'd1);
    chk("same_edge_ovr", 32'(bus0.overrun), 32'd0);
    read_word();
    chk("same_edge_new", 32'(rd_w0), 32'h12);

    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    pulse_reset();
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    read_word();
    chk("post_rst_word", 32'(rd_w0), 32'h4D);

    if (PAR) begin
      send_word(8'h4D, 1'b0, 1'b1, 1'b0);
`ifdef SIPORT_PARITY_EN
      chk("perr_bad", 32'(bus0.parity_err), 32'd1);
`endif
      read_word();
      send_word(8'h4D, 1'b0, 1'b0, 1'b0);
`ifdef SIPORT_PARITY_EN
      chk("perr_good", 32'(bus0.parity_err), 32'd0);
`endif
      read_word();
    end

    for (int n = 0; n < 3000; n++)
      step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
